// File: rtl/alu_out_stage.sv
// alu_out_stage: captures one execution-unit result per transaction,
// selected by the decoder's one-hot enables, and buffers it in a 2-entry
// skid FIFO behind a valid/ready handshake. Transactions whose enables
// are not exactly one-hot are dropped, counted and flagged.
//
// Handshake: a transfer happens on a rising CLK edge when valid and ready
// are both high on that edge; valid never drops without a transfer, and
// the payload holds stable while valid is high and ready is low.
// in_ready depends only on the registered count and RST, never on
// out_ready, so there is no combinational path through this stage.
module alu_out_stage #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ari_EN,
    input  logic             log_EN,
    input  logic             cmp_EN,
    input  logic             shift_EN,
    input  logic [WIDTH-1:0] ari_out,
    input  logic             ari_carry,
    input  logic [WIDTH-1:0] log_out,
    input  logic [WIDTH-1:0] cmp_out,
    input  logic [WIDTH-1:0] shift_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic [3:0]       unit_flag,
    output logic             err_sticky,
    output logic [7:0]       drop_cnt
);

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] r_data  [2];
    logic             r_carry [2];
    logic [3:0]       r_tag   [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    // Registered copy of the head entry; holds its last value when empty
    logic [WIDTH-1:0] r_alu_out;
    logic             r_carry_out;
    logic [3:0]       r_unit_flag;
    logic             r_err_sticky;
    logic [7:0]       r_drop_cnt;

    logic [3:0]       w_en;
    logic             w_onehot;
    logic             w_accept;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic [WIDTH-1:0] w_data;
    logic             w_carry;
    logic             w_rptr_nx;
    logic [1:0]       w_count_nx;
    logic [WIDTH-1:0] w_head_data;
    logic             w_head_carry;
    logic [3:0]       w_head_tag;

    assign w_en      = {shift_EN, cmp_EN, log_EN, ari_EN};
    assign w_onehot  = (w_en != 4'd0) && ((w_en & (w_en - 4'd1)) == 4'd0);
    assign in_ready  = !RST && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_onehot;
    assign w_drop    = w_accept && !w_onehot;
    assign w_pop     = out_valid && out_ready;

    // Select the unit result and carry for a legal one-hot transaction
    always_comb begin
        w_data  = '0;
        w_carry = 1'b0;
        case (w_en)
            4'b0001: begin
                w_data  = ari_out;
                w_carry = ari_carry;
            end
            4'b0010: w_data = log_out;
            4'b0100: w_data = cmp_out;
            4'b1000: w_data = shift_out;
            default: ;
        endcase
    end

    // Next read pointer, next count and the entry that will be at the head
    always_comb begin
        w_rptr_nx  = w_pop ? ~r_rptr : r_rptr;
        w_count_nx = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nx = r_count + 2'd1;
            2'b01:   w_count_nx = r_count - 2'd1;
            default: w_count_nx = r_count;
        endcase
        // A push landing in the slot that becomes the head bypasses storage
        if (w_push && (r_wptr == w_rptr_nx)) begin
            w_head_data  = w_data;
            w_head_carry = w_carry;
            w_head_tag   = w_en;
        end else begin
            w_head_data  = r_data[w_rptr_nx];
            w_head_carry = r_carry[w_rptr_nx];
            w_head_tag   = r_tag[w_rptr_nx];
        end
    end

    // FIFO storage, pointers and count
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i]  <= '0;
                r_carry[i] <= 1'b0;
                r_tag[i]   <= 4'd0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wptr]  <= w_data;
                r_carry[r_wptr] <= w_carry;
                r_tag[r_wptr]   <= w_en;
                r_wptr          <= ~r_wptr;
            end
            r_rptr  <= w_rptr_nx;
            r_count <= w_count_nx;
        end
    end

    // Output registers track the head entry whenever the FIFO is non-empty
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_out   <= '0;
            r_carry_out <= 1'b0;
            r_unit_flag <= 4'd0;
        end else if (w_count_nx != 2'd0) begin
            r_alu_out   <= w_head_data;
            r_carry_out <= w_head_carry;
            r_unit_flag <= w_head_tag;
        end
    end

    // Illegal-enable error flag and saturating drop counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err_sticky <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else if (w_drop) begin
            r_err_sticky <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign alu_out    = r_alu_out;
    assign carry_out  = r_carry_out;
    assign unit_flag  = r_unit_flag;
    assign err_sticky = r_err_sticky;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_alu_out_stage.sv
// Directed bench for alu_out_stage: reset state, single op, back-pressure,
// streaming with an expected queue, illegal enables and mid-run reset.
module tb_alu_out_stage;

  localparam int WIDTH = 16;

  logic             CLK;
  logic             RST;
  logic             in_valid;
  logic             in_ready;
  logic             ari_EN;
  logic             log_EN;
  logic             cmp_EN;
  logic             shift_EN;
  logic [WIDTH-1:0] ari_out;
  logic             ari_carry;
  logic [WIDTH-1:0] log_out;
  logic [WIDTH-1:0] cmp_out;
  logic [WIDTH-1:0] shift_out;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic [3:0]       unit_flag;
  logic             err_sticky;
  logic [7:0]       drop_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // expected head entry: {tag, carry, data}
  logic [20:0] exp_q[$];

  alu_out_stage #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ari_EN     (ari_EN),
    .log_EN     (log_EN),
    .cmp_EN     (cmp_EN),
    .shift_EN   (shift_EN),
    .ari_out    (ari_out),
    .ari_carry  (ari_carry),
    .log_out    (log_out),
    .cmp_out    (cmp_out),
    .shift_out  (shift_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .unit_flag  (unit_flag),
    .err_sticky (err_sticky),
    .drop_cnt   (drop_cnt)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // drive a transaction with raw enables; non-selected units carry noise
  task automatic drive_en(input logic v, input logic [3:0] en,
                          input logic [WIDTH-1:0] d, input logic c);
    in_valid  = v;
    ari_EN    = en[0];
    log_EN    = en[1];
    cmp_EN    = en[2];
    shift_EN  = en[3];
    ari_out   = en[0] ? d : WIDTH'($urandom_range(0, 65535));
    log_out   = en[1] ? d : WIDTH'($urandom_range(0, 65535));
    cmp_out   = en[2] ? d : WIDTH'($urandom_range(0, 65535));
    shift_out = en[3] ? d : WIDTH'($urandom_range(0, 65535));
    ari_carry = en[0] ? c : 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ari_EN   = 1'b0;
    log_EN   = 1'b0;
    cmp_EN   = 1'b0;
    shift_EN = 1'b0;
  endtask

  initial begin
    logic [20:0] e;
    logic [3:0]  en;
    logic [WIDTH-1:0] d;
    logic c;

    RST       = 1'b1;
    out_ready = 1'b0;
    ari_out   = '0;
    log_out   = '0;
    cmp_out   = '0;
    shift_out = '0;
    ari_carry = 1'b0;
    idle();

    // reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_alu_out", 32'(alu_out), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_flag", 32'(unit_flag), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    RST = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single arithmetic op
    out_ready = 1'b1;
    drive_en(1'b1, 4'b0001, 16'h1234, 1'b1);
    tick();
    idle();
    check("ari_valid", 32'(out_valid), 32'd1);
    check("ari_data", 32'(alu_out), 32'h1234);
    check("ari_carry", 32'(carry_out), 32'd1);
    check("ari_flag", 32'(unit_flag), 32'b0001);
    tick();
    check("ari_drain", 32'(out_valid), 32'd0);

    // back-pressure
    out_ready = 1'b0;
    drive_en(1'b1, 4'b0010, 16'h00FF, 1'b0);
    tick();
    check("bp1_in_ready", 32'(in_ready), 32'd1);
    check("bp1_data", 32'(alu_out), 32'h00FF);
    check("bp1_flag", 32'(unit_flag), 32'b0010);
    check("bp1_carry", 32'(carry_out), 32'd0);
    drive_en(1'b1, 4'b0100, 16'h0001, 1'b0);
    tick();
    check("bp2_in_ready", 32'(in_ready), 32'd0);
    check("bp2_data", 32'(alu_out), 32'h00FF);
    drive_en(1'b1, 4'b1000, 16'h8000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_data", 32'(alu_out), 32'h00FF);
      check("bp_stall_flag", 32'(unit_flag), 32'b0010);
      check("bp_stall_ready", 32'(in_ready), 32'd0);
    end
    idle();
    out_ready = 1'b1;
    tick();
    check("bp_pop1_valid", 32'(out_valid), 32'd1);
    check("bp_pop1_data", 32'(alu_out), 32'h0001);
    check("bp_pop1_flag", 32'(unit_flag), 32'b0100);
    check("bp_pop1_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_pop2_valid", 32'(out_valid), 32'd0);

    // streaming: one result per cycle, in order
    for (int i = 0; i < 20; i++) begin
      en = 4'b0001 << (i % 4);
      d  = 16'hA000 + 16'(i * 16'h0111);
      c  = 1'(i >> 2);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      drive_en(1'b1, en, d, c);
      exp_q.push_back({en, (en == 4'b0001) ? c : 1'b0, d});
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      e = exp_q.pop_front();
      check("stream_head", 32'({unit_flag, carry_out, alu_out}), 32'(e));
    end
    idle();
    tick();
    check("stream_drain", 32'(out_valid), 32'd0);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // illegal enables
    drive_en(1'b1, 4'b0000, 16'h5555, 1'b0);
    tick();
    check("ill0_valid", 32'(out_valid), 32'd0);
    check("ill0_in_ready", 32'(in_ready), 32'd1);
    drive_en(1'b1, 4'b0011, 16'h6666, 1'b1);
    tick();
    idle();
    check("ill1_valid", 32'(out_valid), 32'd0);
    check("ill_err", 32'(err_sticky), 32'd1);
    check("ill_drop2", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 300; i++) begin
      drive_en(1'b1, (i % 2 == 0) ? 4'b1100 : 4'b1111, 16'(i), 1'b0);
      tick();
    end
    idle();
    tick();
    check("ill_drop_sat", 32'(drop_cnt), 32'd255);
    check("ill_err_hold", 32'(err_sticky), 32'd1);
    check("ill_no_valid", 32'(out_valid), 32'd0);

    // reset mid-operation with a full FIFO
    out_ready = 1'b0;
    drive_en(1'b1, 4'b1000, 16'hBEEF, 1'b0);
    tick();
    drive_en(1'b1, 4'b0001, 16'hCAFE, 1'b1);
    tick();
    idle();
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_data", 32'(alu_out), 32'hBEEF);
    RST = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready2", 32'(in_ready), 32'd0);
    check("mid_rst_err", 32'(err_sticky), 32'd0);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    RST = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("after_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
